deinterleaver_4_4: RTL and testbench
====================================

# deinterleaver_4_4

- Downstream counterpart of the 4x4 block interleaver.
- Accepts the interleaved 8-bit symbol stream, one 16-symbol block at a time, and restores the original order by transposing the 4x4 block.
- Ping-pong buffered: one bank fills while the other drains, so back-to-back blocks stream without stalls.
- Sits between the channel/transport stage and the symbol consumer.

## Interface

- `ROWS`, 4: block rows; fixed, not overridable.
- `COLS`, 4: block columns; fixed, not overridable.
- `DW`, 8: symbol width.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_i` in 1: `data_i` carries an interleaved symbol this cycle.
- `data_i` in `DW`: interleaved input symbol.
- `valid_o` out 1: `data_o` carries a deinterleaved symbol.
- `data_o` out `DW`: deinterleaved output symbol, registered.
- `sof_o` out 1: high with the first output symbol of each block.
- `blk_cnt_o` out 8: completed-block counter; present only when `DEINTLV_BLKCNT_EN` is defined.

## Operation

- **Storage:** two banks of 16 x `DW`.
- **Writer:**
  - `wr_bank` (1b) and `wr_cnt` (4b); writes `data_i` to `bank[wr_bank][wr_cnt]` on each `valid_i`.
  - `wr_cnt` wraps 15 -> 0.
  - On that wrap: `wr_bank` toggles and a drain request is raised for the just-filled bank.
  - Input gaps (`valid_i` = 0) are allowed anywhere; the counter holds.
- **Reader FSM:**
  - IDLE: `valid_o` = 0. On drain request -> DRAIN with `rd_bank` = filled bank and `rd_cnt` = 0.
  - DRAIN: each cycle `data_o` <= `bank[rd_bank][{rd_cnt[1:0], rd_cnt[3:2]}]`, `valid_o` <= 1, `rd_cnt`++.
  - At `rd_cnt` = 15, a pending drain request re-enters DRAIN on the other bank with no gap; otherwise -> IDLE.
  - Address transpose: input position j = 4*c + r is output at position i = 4*r + c.
- **Invariant:** drain (exactly 16 cycles) always finishes no later than the cycle the other bank completes, because a fill needs at least 16 `valid_i` cycles. At most one drain request is ever pending, and a filling bank is never the draining bank.
- **`sof_o`:** high in the output cycle where `rd_cnt` was 0.
- **Reset values:**
  - `valid_o` = 0, `sof_o` = 0, `data_o` = 0.
  - `wr_cnt` = 0, `rd_cnt` = 0, `wr_bank` = 0, FSM = IDLE, `blk_cnt_o` = 0.
  - Bank contents are not reset.
- **Reset mid-operation:** the partial input block is discarded and any in-progress drain is aborted. The next `valid_i` after reset is symbol 0 of a new block.

## Timing

- Latency: last input symbol of a block is accepted at edge t; the first output is valid after edge t+1; outputs occupy cycles t+1..t+16.
- Continuous input (`valid_i` held high) gives continuous output: `valid_o` stays high from the end of the first block, with `sof_o` every 16 cycles.
- Same cycle as a bank's final write, the reader may still be outputting symbol 15 of the previous block; the new drain starts the next cycle.
- No backpressure: the consumer must accept every `valid_o` cycle.

## Configuration

- `DEINTLV_BLKCNT_EN` defined:
  - `blk_cnt_o` port and counter exist.
  - Increments on the cycle a drain completes (last symbol out); wraps 255 -> 0; cleared by `rst`.
- `DEINTLV_BLKCNT_EN` undefined: port and counter absent; all other behaviour identical.

## Structure

- **Package `interleaver_pkg`:**
  - Constants `ROWS`, `COLS`, `BLK_LEN` (16), `ADDR_W` (4).
  - Transpose-address function, shared with the interleaver.
- **Sub-module `deint_pp_ram`:**
  - Two-bank 16 x `DW` register array.
  - One write port (bank, addr, data, we).
  - One asynchronous read port (bank, addr).
- **Top level:** counters, FSM, output register, optional block counter.

## Test plan

- Single block 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15 with `valid_i` continuous -> `data_o` = 0..15 on 16 consecutive cycles starting one cycle after the last input; `sof_o` high with 0 only.
- Three back-to-back blocks (second block offset +16, third +32) -> 48 contiguous `valid_o` cycles, in-order 0..47, `sof_o` at output indices 0, 16, 32.
- Block with `valid_i` low every other cycle -> identical output values; drain still starts one cycle after the 16th accepted symbol and outputs 16 contiguous cycles.
- `rst` pulsed after 9 input symbols, then a full fresh block -> no output from the partial block; fresh block restored correctly.
- `rst` pulsed at drain output index 5 -> `valid_o` = 0 the cycle after reset is sampled; no remaining symbols emitted.
- With `DEINTLV_BLKCNT_EN`: 257 back-to-back blocks -> `blk_cnt_o` reads 1 after the first drain and 1 again after block 257 (wrap).

Source files
------------

// File: rtl/interleaver_pkg.sv
// Shared definitions for the 4x4 block interleaver / deinterleaver pair.
// Contents:
//   ROWS, COLS   : block geometry (fixed 4x4)
//   BLK_LEN      : symbols per block
//   ADDR_W       : in-block address width
//   LAST_ADDR    : address of the final symbol in a block
//   transpose_addr() : maps row-major index 4*r+c to column-major 4*c+r
package interleaver_pkg;

    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int BLK_LEN = ROWS * COLS;
    localparam int ADDR_W  = 4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = 4'd15;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_DRAIN = 1'b1
    } rd_state_e;

    // Swapping the two 2-bit halves transposes a 4x4 index: 4*r+c <-> 4*c+r.
    function automatic logic [ADDR_W-1:0] transpose_addr(input logic [ADDR_W-1:0] a);
        return {a[1:0], a[3:2]};
    endfunction

endpackage

// File: rtl/deint_pp_ram.sv
// Two-bank ping-pong symbol store for the deinterleaver.
// Ports:
//   clk      : write clock
//   we_i     : write enable
//   wbank_i  : bank being written
//   waddr_i  : write address within the bank
//   wdata_i  : symbol to write
//   rbank_i  : bank being read
//   raddr_i  : read address within the bank
//   rdata_o  : asynchronous read data
// Contents are intentionally not reset.
module deint_pp_ram
    import interleaver_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              wbank_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DW-1:0]     wdata_i,
    input  logic              rbank_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DW-1:0]     rdata_o
);

    logic [DW-1:0] mem_q [2][BLK_LEN];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wbank_i][waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rbank_i][raddr_i];

endmodule

// File: rtl/deinterleaver_4_4.sv
// 4x4 block deinterleaver with ping-pong buffering.
// A block of 16 interleaved symbols is written in arrival order into one
// bank while the other bank is drained in transposed order.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   valid_i   : data_i carries a symbol
//   data_i    : interleaved input symbol
//   valid_o   : data_o carries a deinterleaved symbol
//   data_o    : deinterleaved output symbol (registered)
//   sof_o     : first output symbol of a block
//   blk_cnt_o : completed-block counter (only with DEINTLV_BLKCNT_EN)
// Build option: define DEINTLV_BLKCNT_EN to add the block counter.
module deinterleaver_4_4
    import interleaver_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          sof_o
`ifdef DEINTLV_BLKCNT_EN
    ,
    output logic [7:0]    blk_cnt_o
`endif
);

    // Writer
    logic [ADDR_W-1:0] wr_cnt_q;
    logic              wr_bank_q;
    logic              fill_done;

    assign fill_done = valid_i && (wr_cnt_q == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
        end else if (valid_i) begin
            wr_cnt_q <= wr_cnt_q + 4'd1;
            if (fill_done) begin
                wr_bank_q <= ~wr_bank_q;
            end
        end
    end

    // Reader
    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              rd_bank_q, rd_bank_d;
    logic              pend_q, pend_d;
    logic              pend_bank_q, pend_bank_d;
    logic              valid_q, valid_d;
    logic              sof_q, sof_d;
    logic [DW-1:0]     data_q, data_d;
    logic [DW-1:0]     rd_data;
    logic              req_any;
    logic              req_bank;
    logic              blk_done;

    deint_pp_ram #(.DW(DW)) u_ram (
        .clk     (clk),
        .we_i    (valid_i && !rst),
        .wbank_i (wr_bank_q),
        .waddr_i (wr_cnt_q),
        .wdata_i (data_i),
        .rbank_i (rd_bank_q),
        .raddr_i (transpose_addr(rd_cnt_q)),
        .rdata_o (rd_data)
    );

    // A fill completing this cycle is taken directly so the drain can start
    // on the next edge; the pending register only covers a request that
    // lands mid-drain, which the fill/drain rate balance should never cause.
    assign req_any  = fill_done || pend_q;
    assign req_bank = fill_done ? wr_bank_q : pend_bank_q;

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        rd_bank_d   = rd_bank_q;
        pend_d      = pend_q;
        pend_bank_d = pend_bank_q;
        valid_d     = 1'b0;
        sof_d       = 1'b0;
        data_d      = data_q;
        blk_done    = 1'b0;
        unique case (state_q)
            RD_IDLE: begin
                if (req_any) begin
                    state_d   = RD_DRAIN;
                    rd_bank_d = req_bank;
                    rd_cnt_d  = '0;
                    pend_d    = 1'b0;
                end
            end
            RD_DRAIN: begin
                valid_d  = 1'b1;
                data_d   = rd_data;
                sof_d    = (rd_cnt_q == '0);
                rd_cnt_d = rd_cnt_q + 4'd1;
                if (rd_cnt_q == LAST_ADDR) begin
                    blk_done = 1'b1;
                    if (req_any) begin
                        // Chain straight into the next bank, no bubble.
                        rd_bank_d = req_bank;
                        pend_d    = 1'b0;
                    end else begin
                        state_d = RD_IDLE;
                    end
                end else if (fill_done) begin
                    pend_d      = 1'b1;
                    pend_bank_d = wr_bank_q;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RD_IDLE;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_bank_q <= 1'b0;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            pend_q      <= pend_d;
            pend_bank_q <= pend_bank_d;
            valid_q     <= valid_d;
            sof_q       <= sof_d;
            data_q      <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign sof_o   = sof_q;
    assign data_o  = data_q;

`ifdef DEINTLV_BLKCNT_EN
    logic [7:0] blk_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q <= '0;
        end else if (blk_done) begin
            blk_cnt_q <= blk_cnt_q + 8'd1;
        end
    end

    assign blk_cnt_o = blk_cnt_q;
`else
    logic unused_blk_done;
    assign unused_blk_done = blk_done;
`endif

endmodule

// File: tb/tb_deinterleaver_4_4.sv
// Directed self-checking bench for deinterleaver_4_4.
// Outputs are captured at the falling edge into queues together with the
// rising-edge count, then compared against hand-built expectations.
module tb_deinterleaver_4_4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_i = 1'b0;
    logic [7:0] data_i = '0;
    logic       valid_o;
    logic [7:0] data_o;
    logic       sof_o;
`ifdef DEINTLV_BLKCNT_EN
    logic [7:0] blk_cnt_o;
`endif

    deinterleaver_4_4 #(.DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .sof_o     (sof_o)
`ifdef DEINTLV_BLKCNT_EN
        ,
        .blk_cnt_o (blk_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] q_data[$];
    logic       q_sof[$];
    int         q_cyc[$];

    always @(negedge clk) begin
        if (valid_o) begin
            q_data.push_back(data_o);
            q_sof.push_back(sof_o);
            q_cyc.push_back(cyc);
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Interleaved order of one block 0..15 (column-major read of a row-major fill).
    logic [7:0] ILV [16] = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd1, 8'd5, 8'd9, 8'd13,
                             8'd2, 8'd6, 8'd10, 8'd14, 8'd3, 8'd7, 8'd11, 8'd15};

    task automatic send(input logic [7:0] d);
        valid_i = 1'b1;
        data_i  = d;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_sof.delete();
        q_cyc.delete();
    endtask

    // Check n in-order outputs starting at value base, first one at edge t0.
    task automatic check_stream(input string tag, input int n, input int base, input int t0);
        chk($sformatf("%s_count", tag), 32'(q_data.size()), 32'(n));
        for (int i = 0; i < n && i < q_data.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), 32'(q_data[i]), 32'(base + i));
            chk($sformatf("%s_sof%0d", tag, i), 32'(q_sof[i]), 32'((i % 16) == 0));
            chk($sformatf("%s_cyc%0d", tag, i), 32'(q_cyc[i]), 32'(t0 + 1 + i));
        end
    endtask

    int t_last;

    initial begin
        idle(3);
        rst = 1'b0;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_sof",   32'(sof_o),   32'd0);
        chk("rst_data",  32'(data_o),  32'd0);
`ifdef DEINTLV_BLKCNT_EN
        chk("rst_blkcnt", 32'(blk_cnt_o), 32'd0);
`endif

        // Single block, continuous input
        clear_q();
        for (int j = 0; j < 16; j++) send(ILV[j]);
        t_last = cyc;
        idle(24);
        check_stream("single", 16, 0, t_last);

        // Three back-to-back blocks
        clear_q();
        t_last = 0;
        for (int b = 0; b < 3; b++) begin
            for (int j = 0; j < 16; j++) send(ILV[j] + 8'(16 * b));
            if (b == 0) t_last = cyc;
        end
        idle(24);
        check_stream("b2b", 48, 0, t_last);

        // Input with a gap after every symbol
        clear_q();
        for (int j = 0; j < 16; j++) begin
            send(ILV[j] + 8'h80);
            if (j == 15) t_last = cyc;
            idle(1);
        end
        idle(24);
        check_stream("gaps", 16, 8'h80, t_last);

        // Reset after a partial block, then a fresh block
        clear_q();
        for (int j = 0; j < 9; j++) send(8'hF0 + 8'(j));
        pulse_rst();
        for (int j = 0; j < 16; j++) send(ILV[j] + 8'h40);
        t_last = cyc;
        idle(24);
        check_stream("partial", 16, 8'h40, t_last);

        // Reset in the middle of a drain: index 5 is showing when rst is sampled
        clear_q();
        for (int j = 0; j < 16; j++) send(ILV[j] + 8'h20);
        idle(6);
        chk("mid_idx5", 32'(data_o), 32'h25);
        pulse_rst();
        chk("mid_valid", 32'(valid_o), 32'd0);
        chk("mid_data",  32'(data_o),  32'd0);
        idle(24);
        chk("mid_count", 32'(q_data.size()), 32'd6);

`ifdef DEINTLV_BLKCNT_EN
        pulse_rst();
        chk("bc_rst", 32'(blk_cnt_o), 32'd0);
        for (int b = 0; b < 257; b++) begin
            for (int j = 0; j < 16; j++) send(ILV[j]);
            // The edge that accepts block 2's last symbol also emits block 1's last.
            if (b == 1) chk("bc_first", 32'(blk_cnt_o), 32'd1);
        end
        idle(24);
        chk("bc_wrap", 32'(blk_cnt_o), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
